// File: rtl/ddram_clear_checker.sv
// Read-back verifier for the DDR3 clear helper: bursts through a word range on the
// DDRAM read port and counts words that differ from the cleared pattern.
module ddram_clear_checker #(
    parameter logic [28:0] BASE   = 29'h0000000,
    parameter logic [31:0] WORDS  = 32'd4096,
    parameter logic [7:0]  BURST  = 8'd128,
    parameter logic [63:0] EXPECT = 64'h0
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        start,
    input  logic        DDRAM_BUSY,
    output logic        DDRAM_RD,
    output logic [28:0] DDRAM_ADDR,
    output logic [7:0]  DDRAM_BURSTCNT,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [28:0] first_err_addr,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DONE} state_t;

    // Handshake: a request is taken on any cycle with DDRAM_RD=1 and DDRAM_BUSY=0;
    // RD/ADDR/BURSTCNT hold while BUSY=1, and one request is outstanding at a time.
    state_t      state_q;
    logic        rd_q;
    logic [28:0] addr_q;
    logic [7:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [15:0] err_q;
    logic [28:0] first_q;
    logic [31:0] remaining_q;
    logic [7:0]  beats_q;

    logic [7:0]  beat_off_d;
    logic [28:0] beat_addr_d;
    logic        beat_bad_d;
    logic [15:0] err_d;
    logic [31:0] remaining_d;

    function automatic logic [7:0] burst_len(input logic [31:0] rem);
        if (rem >= {24'd0, BURST}) return BURST;
        return rem[7:0];
    endfunction

    always_comb begin
        beat_off_d  = cnt_q - beats_q;
        beat_addr_d = addr_q + {21'd0, beat_off_d};
        beat_bad_d  = (DDRAM_DOUT != EXPECT);
        err_d       = err_q;
        if (beat_bad_d && err_q != 16'hFFFF) err_d = err_q + 16'd1;
        remaining_d = remaining_q - {24'd0, cnt_q};
    end

    always_ff @(posedge clk_sys) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            rd_q        <= 1'b0;
            addr_q      <= BASE;
            cnt_q       <= BURST;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= 16'd0;
            first_q     <= 29'd0;
            remaining_q <= WORDS;
            beats_q     <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_REQ;
                        rd_q        <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        err_q       <= 16'd0;
                        first_q     <= 29'd0;
                        addr_q      <= BASE;
                        remaining_q <= WORDS;
                        cnt_q       <= burst_len(WORDS);
                    end
                end
                S_REQ: begin
                    if (!DDRAM_BUSY) begin
                        rd_q    <= 1'b0;
                        beats_q <= cnt_q;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (DDRAM_DOUT_READY) begin
                        err_q   <= err_d;
                        // err_q never returns to zero within a pass, so zero marks the first miss
                        if (beat_bad_d && err_q == 16'd0) first_q <= beat_addr_d;
                        beats_q <= beats_q - 8'd1;
                        if (beats_q == 8'd1) begin
                            remaining_q <= remaining_d;
                            addr_q      <= addr_q + {21'd0, cnt_q};
                            if (remaining_d == 32'd0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                pass_q  <= (err_d == 16'd0);
                            end else begin
                                state_q <= S_REQ;
                                rd_q    <= 1'b1;
                                cnt_q   <= burst_len(remaining_d);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign DDRAM_RD       = rd_q;
    assign DDRAM_ADDR     = addr_q;
    assign DDRAM_BURSTCNT = cnt_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ddram_clear_checker.sv
// Bench for ddram_clear_checker: randomized DDRAM responder, expected requests and
// results queued per pass, and a monitor comparing whatever the DUT presents.
module tb_ddram_clear_checker;

    localparam logic [28:0] BASE_P  = 29'h1FFFFF00;
    localparam int          WORDS_P = 300;
    localparam int          BURST_P = 128;
    localparam logic [63:0] EXP_P   = 64'hDEAD_BEEF_0000_5A5A;

    logic        clk_sys = 1'b0;
    logic        RESET = 1'b0;
    logic        start = 1'b0;
    logic        DDRAM_BUSY = 1'b0;
    logic        DDRAM_RD;
    logic [28:0] DDRAM_ADDR;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [63:0] DDRAM_DOUT = 64'd0;
    logic        DDRAM_DOUT_READY = 1'b0;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [28:0] first_err_addr;
    logic [1:0]  dbg_state_o;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_req_q[$];
    logic [45:0] exp_res_q[$];
    logic [63:0] data_m[WORDS_P];

    ddram_clear_checker #(
        .BASE(BASE_P), .WORDS(32'(WORDS_P)), .BURST(8'(BURST_P)), .EXPECT(EXP_P)
    ) dut (
        .clk_sys(clk_sys), .RESET(RESET), .start(start), .DDRAM_BUSY(DDRAM_BUSY),
        .DDRAM_RD(DDRAM_RD), .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
        .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .busy(busy),
        .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
        .dbg_state_o(dbg_state_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Monitor: pops expectations whenever a request is accepted or done rises.
    initial begin
        logic done_seen;
        logic [36:0] er;
        logic [45:0] eres;
        done_seen = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (RESET && DDRAM_RD && !DDRAM_BUSY) begin
                if (exp_req_q.size() == 0) begin
                    check("req_extra", 128'({DDRAM_ADDR, DDRAM_BURSTCNT}), 128'(0));
                end else begin
                    er = exp_req_q.pop_front();
                    check("req_addr_cnt", 128'({DDRAM_ADDR, DDRAM_BURSTCNT}), 128'(er));
                end
            end
            if (done && !done_seen) begin
                if (exp_res_q.size() == 0) begin
                    check("res_extra", 128'({pass, err_count, first_err_addr}), 128'(0));
                end else begin
                    eres = exp_res_q.pop_front();
                    check("result", 128'({pass, err_count, first_err_addr}), 128'(eres));
                end
            end
            done_seen = done;
        end
    end

    // mode: 0 random errors, 1 errors at words 37/200, 2 three errors, 3 clean
    task automatic run_pass(input int mode, input int abort_at, input bit poke);
        int errs;
        logic [28:0] first;
        int off;
        int cnt;
        errs = 0;
        first = 29'd0;
        for (int i = 0; i < WORDS_P; i++) begin
            data_m[i] = EXP_P;
            if (mode == 0 && $urandom_range(0, 15) == 0) data_m[i] = {$urandom, $urandom};
        end
        if (mode == 1) begin
            data_m[37]  = EXP_P ^ 64'h1;
            data_m[200] = EXP_P ^ 64'h1;
        end
        if (mode == 2) begin
            data_m[10]  = ~EXP_P;
            data_m[150] = 64'd0;
            data_m[299] = EXP_P ^ 64'h8000_0000_0000_0000;
        end
        for (int i = 0; i < WORDS_P; i++) begin
            if (data_m[i] != EXP_P) begin
                if (errs == 0) first = BASE_P + 29'(i);
                if (errs < 65535) errs++;
            end
        end
        for (int o = 0; o < WORDS_P; o += BURST_P) begin
            cnt = (WORDS_P - o > BURST_P) ? BURST_P : WORDS_P - o;
            exp_req_q.push_back({BASE_P + 29'(o), 8'(cnt)});
        end
        if (abort_at < 0) exp_res_q.push_back({(errs == 0), 16'(errs), first});

        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_state", 128'({busy, done, pass, err_count, first_err_addr, DDRAM_ADDR, DDRAM_RD}),
              128'({1'b1, 1'b0, 1'b0, 16'h0, 29'h0, BASE_P, 1'b1}));

        off = 0;
        while (off < WORDS_P) begin
            cnt = (WORDS_P - off > BURST_P) ? BURST_P : WORDS_P - off;
            for (int s = $urandom_range(0, 5); s > 0; s--) begin
                DDRAM_BUSY       = 1'b1;
                DDRAM_DOUT_READY = 1'($urandom_range(0, 1));
                DDRAM_DOUT       = ~EXP_P;
                tick();
                check("req_hold", 128'({DDRAM_RD, DDRAM_ADDR, DDRAM_BURSTCNT}),
                      128'({1'b1, BASE_P + 29'(off), 8'(cnt)}));
            end
            DDRAM_BUSY       = 1'b0;
            DDRAM_DOUT_READY = 1'b0;
            tick();
            check("req_accept", 128'(DDRAM_RD), 128'(0));
            for (int k = 0; k < cnt; k++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    DDRAM_DOUT_READY = 1'b0;
                    DDRAM_DOUT       = {$urandom, $urandom};
                    tick();
                end
                DDRAM_DOUT_READY = 1'b1;
                DDRAM_DOUT       = data_m[off + k];
                start            = poke && off == 0 && k == 5;
                if (off + k == abort_at) RESET = 1'b0;
                tick();
                start = 1'b0;
                DDRAM_DOUT_READY = 1'b0;
                if (!RESET) begin
                    RESET = 1'b1;
                    check("abort_reset", 128'({DDRAM_RD, DDRAM_ADDR, DDRAM_BURSTCNT, busy, done, pass,
                                               err_count, first_err_addr, dbg_state_o}),
                          128'({1'b0, BASE_P, 8'(BURST_P), 1'b0, 1'b0, 1'b0, 16'h0, 29'h0, 2'd0}));
                    for (int r = k + 1; r < cnt; r++) begin
                        DDRAM_DOUT_READY = 1'b1;
                        DDRAM_DOUT       = ~EXP_P;
                        tick();
                    end
                    DDRAM_DOUT_READY = 1'b0;
                    tick();
                    check("abort_ignore", 128'({err_count, busy, done, DDRAM_RD}), 128'(0));
                    exp_req_q.delete();
                    return;
                end
            end
            off += cnt;
            if (off < WORDS_P)
                check("next_req", 128'({DDRAM_RD, done}), 128'({1'b1, 1'b0}));
            else
                check("done_lat", 128'({done, busy, DDRAM_RD}), 128'({1'b1, 1'b0, 1'b0}));
        end
        for (int w = $urandom_range(0, 3); w > 0; w--) tick();
        check("done_hold", 128'({done, busy}), 128'({1'b1, 1'b0}));
    endtask

    initial begin
        RESET = 1'b0;
        repeat (3) tick();
        check("reset_vals", 128'({DDRAM_RD, DDRAM_ADDR, DDRAM_BURSTCNT, busy, done, pass,
                                  err_count, first_err_addr, dbg_state_o}),
              128'({1'b0, BASE_P, 8'(BURST_P), 1'b0, 1'b0, 1'b0, 16'h0, 29'h0, 2'd0}));
        RESET = 1'b1;
        tick();
        run_pass(3, -1, 1'b0);
        run_pass(1, -1, 1'b0);
        run_pass(2, -1, 1'b0);
        run_pass(3, -1, 1'b0);
        run_pass(0, -1, 1'b1);
        run_pass(0, $urandom_range(10, 250), 1'b0);
        run_pass(3, -1, 1'b0);
        for (int p = 0; p < 3; p++) run_pass(0, -1, 1'($urandom_range(0, 1)));
        repeat (4) tick();
        check("req_q_empty", 128'(exp_req_q.size()), 128'(0));
        check("res_q_empty", 128'(exp_res_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
